// File: rtl/ssd_display_driver.sv
// ---------------------------------------------------------------------------
// ssd_display_driver
//
// Takes the CPU's 13-bit debug value and shows it in decimal on a 4-digit,
// common-anode 7-segment display. A double-dabble engine converts the value
// to BCD one shift per clock. A conversion starts only when the value differs
// from the last converted one, or when no conversion has completed since
// reset. The four digits are time-multiplexed from a free-running refresh
// counter.
//
// Ports:
//   clk    - system clock, rising-edge active
//   rst    - asynchronous, active-low reset
//   value  - binary value to display (0..8191)
//   anode  - active-low one-hot digit enable, bit0 = ones digit (registered)
//   seg    - active-low segments {g,f,e,d,c,b,a} (registered)
//   busy   - high while a conversion is in progress (registered)
//   done   - one-cycle pulse after a new BCD result is loaded (registered)
//   bcd    - BCD value being displayed {thousands,hundreds,tens,ones}
// ---------------------------------------------------------------------------
module ssd_display_driver #(
  parameter int REFRESH_BITS = 18,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left
  // by one bit, taking in_bit as the new LSB.
  function automatic logic [15:0] dd_step(input logic [15:0] acc, input logic in_bit);
    logic [15:0] adj;
    adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = acc[i*4 +: 4];
      end
    end
    return {adj[14:0], in_bit};
  endfunction

  // BCD digit to active-low segments {g,f,e,d,c,b,a}; nibbles above 9 turn
  // every segment off.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;

  logic [12:0]       shift_r;
  logic [12:0]       cap_r;
  logic [15:0]       acc_r;
  logic [3:0]        cnt_r;
  logic [12:0]       last_r;
  logic              valid_r;
  logic              busy_r;
  logic              done_r;
  logic [15:0]       bcd_r;

  logic [REFRESH_BITS-1:0] refresh_r;
  logic [3:0]        anode_r;
  logic [6:0]        seg_r;

  logic              start_s;
  logic              capture_s;
  logic              shift_s;
  logic              load_s;
  logic [1:0]        digit_s;
  logic [3:0]        nibble_s;
  logic              blank_s;
  logic [6:0]        seg_nxt_s;

  // The value needs converting if nothing has been converted yet or it moved.
  assign start_s = (!valid_r) || (value != last_r);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // cnt_r == 1 means this edge performs the 13th and final shift.
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: datapath strobes for the current state.
  always_comb begin
    capture_s = 1'b0;
    shift_s   = 1'b0;
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
      end
      ST_LOAD: begin
        load_s = 1'b1;
      end
      default: begin
        capture_s = 1'b0;
        shift_s   = 1'b0;
        load_s    = 1'b0;
      end
    endcase
  end

  // Conversion datapath: capture, shift, and load of the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= 13'd0;
      cap_r   <= 13'd0;
      acc_r   <= 16'd0;
      cnt_r   <= 4'd0;
      last_r  <= 13'd0;
      valid_r <= 1'b0;
      bcd_r   <= 16'h0000;
    end else if (capture_s) begin
      shift_r <= value;
      cap_r   <= value;
      acc_r   <= 16'd0;
      cnt_r   <= 4'd13;
    end else if (shift_s) begin
      acc_r   <= dd_step(acc_r, shift_r[12]);
      shift_r <= {shift_r[11:0], 1'b0};
      cnt_r   <= cnt_r - 4'd1;
    end else if (load_s) begin
      bcd_r   <= acc_r;
      last_r  <= cap_r;
      valid_r <= 1'b1;
    end else begin
      shift_r <= shift_r;
    end
  end

  // Status flags: busy follows the next state, so it rises on the capture
  // edge and drops on the load edge; done marks the load edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= load_s;
    end
  end

  assign digit_s = refresh_r[REFRESH_BITS-1 -: 2];

  // Select the BCD nibble for the active digit and decide leading-zero blanking.
  always_comb begin
    nibble_s = 4'd0;
    blank_s  = 1'b0;
    case (digit_s)
      2'd0: begin
        nibble_s = bcd_r[3:0];
        blank_s  = 1'b0;
      end
      2'd1: begin
        nibble_s = bcd_r[7:4];
        blank_s  = (bcd_r[15:4] == 12'd0);
      end
      2'd2: begin
        nibble_s = bcd_r[11:8];
        blank_s  = (bcd_r[15:8] == 8'd0);
      end
      2'd3: begin
        nibble_s = bcd_r[15:12];
        blank_s  = (bcd_r[15:12] == 4'd0);
      end
      default: begin
        nibble_s = 4'd0;
        blank_s  = 1'b0;
      end
    endcase
    if (BLANK_LZ && blank_s) begin
      seg_nxt_s = 7'b1111111;
    end else begin
      seg_nxt_s = seg_decode(nibble_s);
    end
  end

  // Refresh counter and registered digit drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_r <= '0;
      anode_r   <= 4'b1111;
      seg_r     <= 7'b1111111;
    end else begin
      refresh_r <= refresh_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      anode_r   <= ~(4'b0001 << digit_s);
      seg_r     <= seg_nxt_s;
    end
  end

  assign anode = anode_r;
  assign seg   = seg_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign bcd   = bcd_r;

endmodule

// File: tb/tb_ssd_display_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_display_driver
//
// Scoreboard bench for ssd_display_driver. Two instances share the inputs:
// dut blanks leading zeros, dut0 does not. Both use a 4-bit refresh counter,
// so each digit slot lasts 4 clocks. The stimulus pushes the expected BCD
// value for each conversion it triggers. A monitor pops an entry on every
// done pulse and checks the result and the busy length.
// ---------------------------------------------------------------------------
module tb_ssd_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] value;
  logic [3:0]  anode, anode0;
  logic [6:0]  seg, seg0;
  logic        busy, busy0;
  logic        done, done0;
  logic [15:0] bcd, bcd0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          busy_run = 0;

  ssd_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .anode(anode), .seg(seg),
    .busy(busy), .done(done), .bcd(bcd)
  );

  ssd_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .anode(anode0), .seg(seg0),
    .busy(busy0), .done(done0), .bcd(bcd0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step off the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: runs forever, sampling on falling edges.
  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_run = 0;
      end else begin
        if (done) begin
          chk("done_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bcd", bcd, e);
            chk("bcd_nolz", bcd0, e);
            chk("busy_cycles", busy_run, 14);
            chk("busy_at_done", busy, 0);
            chk("done_nolz", done0, 1);
          end
          busy_run = 0;
        end
        if (busy) busy_run++;
      end
    end
  endtask

  // Wait (bounded) for a given anode pattern on a falling edge.
  task automatic wait_anode(input logic [3:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (anode == a) begin
        ok = 1'b1;
        break;
      end
    end
    chk("anode_reached", int'(ok), 1);
  endtask

  task automatic check_digit(input int d, input logic [6:0] s_lz, input logic [6:0] s_nolz);
    bit ok;
    logic [3:0] a;
    a = ~(4'b0001 << d);
    wait_anode(a, ok);
    if (ok) begin
      chk($sformatf("seg_lz_d%0d", d), seg, s_lz);
      chk($sformatf("seg_nolz_d%0d", d), seg0, s_nolz);
    end
  endtask

  task automatic stimulus();
    bit          ok;
    logic [3:0]  exp_an [4];
    logic [6:0]  exp_sg [4];
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_sg[0] = 7'b0011001; exp_sg[1] = 7'b0110000; exp_sg[2] = 7'b0100100; exp_sg[3] = 7'b1111001;

    // Reset held for 3 cycles with value 0.
    rst   = 1'b0;
    value = 13'd0;
    tick(3);
    chk("rst_anode", anode, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 16'h0000);
    exp_q.push_back(16'h0000);
    rst = 1'b1;
    tick(20);
    check_digit(0, 7'b1000000, 7'b1000000);
    check_digit(1, 7'b1111111, 7'b1000000);

    // Maximum value; holding it must not trigger another done.
    tick(1);
    value = 13'd8191;
    exp_q.push_back(16'h8191);
    tick(20);
    tick(20);
    chk("q_after_8191", exp_q.size(), 0);

    // Digit multiplexing sequence for 1234.
    value = 13'd1234;
    exp_q.push_back(16'h1234);
    tick(20);
    wait_anode(4'b0111, ok);
    wait_anode(4'b1110, ok);
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("mux_anode_%0d", i), anode, exp_an[i/4]);
      chk($sformatf("mux_seg_%0d", i), seg, exp_sg[i/4]);
    end

    // Single digit: leading-zero blanking versus all digits shown.
    tick(1);
    value = 13'd7;
    exp_q.push_back(16'h0007);
    tick(20);
    check_digit(0, 7'b1111000, 7'b1111000);
    check_digit(1, 7'b1111111, 7'b1000000);
    check_digit(2, 7'b1111111, 7'b1000000);
    check_digit(3, 7'b1111111, 7'b1000000);

    // Input changes mid-conversion: 100 completes first, then 200.
    tick(1);
    value = 13'd100;
    exp_q.push_back(16'h0100);
    tick(5);
    value = 13'd200;
    exp_q.push_back(16'h0200);
    tick(40);
    chk("q_after_200", exp_q.size(), 0);

    // Change and revert during a conversion: no extra conversion.
    value = 13'd500;
    exp_q.push_back(16'h0500);
    tick(4);
    value = 13'd600;
    tick(4);
    value = 13'd500;
    tick(30);
    chk("q_after_revert", exp_q.size(), 0);

    // Reset during the 7th shift of 4095, then reconversion.
    value = 13'd4095;
    exp_q.push_back(16'h4095);
    tick(8);
    rst = 1'b0;
    #1;
    chk("mid_rst_anode", anode, 4'b1111);
    chk("mid_rst_seg", seg, 7'b1111111);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_bcd", bcd, 16'h0000);
    tick(2);
    rst = 1'b1;
    tick(20);
    chk("q_after_4095", exp_q.size(), 0);
    chk("final_bcd", bcd, 16'h4095);
  endtask

  initial begin
    fork
      stimulus();
      monitor();
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
